// File: rtl/datapath_pipe.sv
// datapath_pipe: pipelined processor datapath. It holds a register bank, an
// operand/constant mux with writeback bypass, a registered execute stage, an
// ALU, an unsigned comparator and a multi-cycle shift-add multiplier. The
// multiplier writes its double-width product into two registers.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   instruction handshake (accept = in_valid && in_ready)
//   in_data, cte        LOAD value and constant operand
//   sel_mux_cte         bit0: A=cte, bit1: B=cte
//   sba, sbb, srd       operand read selects and destination register
//   sula, le            operation code and bank write enable
//   out_valid           one-cycle pulse per completed operation
//   out_data, out_cmp   registered low result and compare {gt,ge,eq,le,lt}
//   out_zero, out_carry registered flags of the last completed operation
//   dbg_sel, dbg_data   combinational bank read port for test
module datapath_pipe #(
  parameter int WIDTH = 8,
  parameter int NREG  = 16,
  parameter int SELW  = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] cte,
  input  logic [1:0]       sel_mux_cte,
  input  logic [SELW-1:0]  sba,
  input  logic [SELW-1:0]  sbb,
  input  logic [SELW-1:0]  srd,
  input  logic [3:0]       sula,
  input  logic             le,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_cmp,
  output logic             out_zero,
  output logic             out_carry,
  input  logic [SELW-1:0]  dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    OP_MUL   = 4'd8;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;
  state_t state, state_n;

  logic [WIDTH-1:0]   bank [NREG];
  logic [WIDTH-1:0]   a_p1, b_p1, din_p1;
  logic [3:0]         op_p1;
  logic [SELW-1:0]    rd_p1;
  logic               le_p1;
  logic [2*WIDTH-1:0] acc_p1, mc_p1;
  logic [WIDTH-1:0]   mp_p1;
  logic [CW-1:0]      cnt_p1;

  // {carry, result} of a single-cycle operation
  function automatic logic [WIDTH:0] alu(input logic [3:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] din);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {(a < b), a - b};
      4'd2:    r = {1'b0, a & b};
      4'd3:    r = {1'b0, a | b};
      4'd4:    r = {1'b0, a ^ b};
      4'd5:    r = {1'b0, ~a};
      4'd6:    r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
      4'd7:    r = {a[0], 1'b0, a[WIDTH-1:1]};
      4'd9:    r = {1'b0, a};
      4'd10:   r = {1'b0, din};
      default: r = '0;
    endcase
    return r;
  endfunction

  // NOP codes and MUL (which has its own writeback path) never use this port
  function automatic logic writes_bank(input logic [3:0] op);
    return (op <= 4'd10) && (op != OP_MUL);
  endfunction

  function automatic logic [4:0] cmp5(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b);
    return {(a > b), (a >= b), (a == b), (a <= b), (a < b)};
  endfunction

  logic [WIDTH:0]     alu_out;
  logic [WIDTH-1:0]   res;
  logic               exec_done, exec_wr, mul_last, accept;
  logic [2*WIDTH-1:0] prod_n;
  logic [SELW-1:0]    rd_hi;
  logic [WIDTH-1:0]   opa_bank, opb_bank, opa, opb;

  assign in_ready  = (state != MUL);
  assign accept    = in_valid && in_ready;
  assign alu_out   = alu(op_p1, a_p1, b_p1, din_p1);
  assign res       = alu_out[WIDTH-1:0];
  assign exec_done = (state == EXEC);
  assign exec_wr   = exec_done && le_p1 && writes_bank(op_p1);
  assign mul_last  = (state == MUL) && (cnt_p1 == CNT_LAST);
  assign prod_n    = acc_p1 + (mp_p1[0] ? mc_p1 : '0);
  assign rd_hi     = rd_p1 + SELW'(1);
  assign dbg_data  = bank[dbg_sel];

  // The op retiring on this edge has not reached the bank yet, so forward it
  assign opa_bank = (exec_wr && (rd_p1 == sba)) ? res : bank[sba];
  assign opb_bank = (exec_wr && (rd_p1 == sbb)) ? res : bank[sbb];
  assign opa      = sel_mux_cte[0] ? cte : opa_bank;
  assign opb      = sel_mux_cte[1] ? cte : opb_bank;

  always_comb begin
    state_n = state;
    case (state)
      IDLE, EXEC: begin
        if (accept) state_n = (sula == OP_MUL) ? MUL : EXEC;
        else        state_n = IDLE;
      end
      MUL:     if (cnt_p1 == CNT_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Execute stage (p1): captured operands plus multiplier iteration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1   <= '0;
      b_p1   <= '0;
      din_p1 <= '0;
      op_p1  <= '0;
      rd_p1  <= '0;
      le_p1  <= 1'b0;
      acc_p1 <= '0;
      mc_p1  <= '0;
      mp_p1  <= '0;
      cnt_p1 <= '0;
    end else if (accept) begin
      a_p1   <= opa;
      b_p1   <= opb;
      din_p1 <= in_data;
      op_p1  <= sula;
      rd_p1  <= srd;
      le_p1  <= le;
      acc_p1 <= '0;
      mc_p1  <= {{WIDTH{1'b0}}, opa};
      mp_p1  <= opb;
      cnt_p1 <= '0;
    end else if (state == MUL) begin
      acc_p1 <= prod_n;
      mc_p1  <= {mc_p1[2*WIDTH-2:0], 1'b0};
      mp_p1  <= {1'b0, mp_p1[WIDTH-1:1]};
      cnt_p1 <= cnt_p1 + CW'(1);
    end
  end

  // Writeback stage (p2): bank update and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) bank[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cmp   <= '0;
      out_zero  <= 1'b0;
      out_carry <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (exec_done) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_zero  <= (res == '0);
        out_carry <= alu_out[WIDTH];
        out_cmp   <= cmp5(a_p1, b_p1);
        if (exec_wr) bank[rd_p1] <= res;
      end else if (mul_last) begin
        out_valid <= 1'b1;
        out_data  <= prod_n[WIDTH-1:0];
        out_zero  <= (prod_n == '0);
        out_carry <= (prod_n[2*WIDTH-1:WIDTH] != '0);
        out_cmp   <= cmp5(a_p1, b_p1);
        if (le_p1) begin
          bank[rd_p1] <= prod_n[WIDTH-1:0];
          bank[rd_hi] <= prod_n[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Testbench for datapath_pipe: directed scenarios plus randomized instruction
// streams, checked by a scoreboard fed from a sequential instruction-set model.
module tb_datapath_pipe;
  localparam int W    = 8;
  localparam int NR   = 16;
  localparam int SW   = 4;
  localparam int MAXV = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid, in_ready, le, out_valid, out_zero, out_carry;
  logic [W-1:0]  in_data, cte, out_data, dbg_data;
  logic [1:0]    sel_mux_cte;
  logic [SW-1:0] sba, sbb, srd, dbg_sel;
  logic [3:0]    sula;
  logic [4:0]    out_cmp;

  always #5 clk = ~clk;

  datapath_pipe #(.WIDTH(W), .NREG(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .cte(cte), .sel_mux_cte(sel_mux_cte), .sba(sba),
    .sbb(sbb), .srd(srd), .sula(sula), .le(le), .out_valid(out_valid),
    .out_data(out_data), .out_cmp(out_cmp), .out_zero(out_zero),
    .out_carry(out_carry), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  typedef struct {
    logic [W-1:0] data;
    logic [4:0]   cmp;
    logic         zero;
    logic         carry;
    int           due;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mbank [NR];
  int           pass_cnt = 0;
  int           total    = 0;
  int           cyc      = 0;
  int           mul_low;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got === expv) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, expv);
  endtask

  // Monitor: every out_valid pulse must match the oldest pending result
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_valid: out_data %0h at cycle %0d, no result pending", out_data, cyc);
      end else begin
        e = q.pop_front();
        check("result{data,cmp,z,c}", {17'd0, out_data, out_cmp, out_zero, out_carry},
              {17'd0, e.data, e.cmp, e.zero, e.carry});
        check("completion_cycle", cyc, e.due);
      end
    end
  end

  // Sequential architectural model: each instruction sees all earlier results
  task automatic model(input logic [3:0] op, input logic [1:0] sel, input int sa, input int sb,
                       input int rd, input logic le_i, input logic [W-1:0] c,
                       input logic [W-1:0] d, input int e0);
    int a, b, r, cy, p;
    exp_t e;
    a  = int'(sel[0] ? c : mbank[sa]);
    b  = int'(sel[1] ? c : mbank[sb]);
    e.cmp = {(a > b), (a >= b), (a == b), (a <= b), (a < b)};
    cy = 0;
    p  = 0;
    case (op)
      4'd0:    begin r = a + b; cy = (r > MAXV) ? 1 : 0; end
      4'd1:    begin r = a - b; cy = (a < b) ? 1 : 0; end
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = MAXV - a;
      4'd6:    begin r = a * 2; cy = (a >= (1 << (W - 1))) ? 1 : 0; end
      4'd7:    begin r = a / 2; cy = a % 2; end
      4'd8:    begin p = a * b; r = p; end
      4'd9:    r = a;
      4'd10:   r = int'(d);
      default: r = 0;
    endcase
    e.data = W'(r & MAXV);
    if (op == 4'd8) begin
      e.zero  = (p == 0);
      e.carry = ((p >> W) != 0);
      e.due   = e0 + W;
      if (le_i) begin
        mbank[rd]            = W'(p & MAXV);
        mbank[(rd + 1) % NR] = W'((p >> W) & MAXV);
      end
    end else begin
      e.zero  = ((r & MAXV) == 0);
      e.carry = (cy != 0);
      e.due   = e0 + 1;
      if (le_i && op <= 4'd10) mbank[rd] = W'(r & MAXV);
    end
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [1:0] sel, input int sa, input int sb,
                       input int rd, input logic le_i, input logic [W-1:0] c,
                       input logic [W-1:0] d);
    int t;
    t = 0;
    sula = op; sel_mux_cte = sel; sba = SW'(sa); sbb = SW'(sb); srd = SW'(rd);
    le = le_i; cte = c; in_data = d; in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      total++;
      $display("FAIL issue_timeout: in_ready %0b, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    model(op, sel, sa, sb, rd, le_i, c, d, cyc);
  endtask

  // Idle cycles with garbage on the instruction inputs, which must be ignored
  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      sula = 4'($urandom); sel_mux_cte = 2'($urandom); sba = SW'($urandom);
      sbb = SW'($urandom); srd = SW'($urandom); le = 1'b1;
      cte = W'($urandom); in_data = W'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    idle(W + 3);
    check("queue_empty", q.size(), 0);
  endtask

  task automatic check_bank();
    for (int i = 0; i < NR; i++) begin
      dbg_sel = SW'(i);
      #1;
      check($sformatf("dbg_r%0d", i), dbg_data, mbank[i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reg(input int i, input logic [W-1:0] v);
    dbg_sel = SW'(i);
    #1;
    check($sformatf("r%0d_value", i), dbg_data, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    in_valid = 0; in_data = 0; cte = 0; sel_mux_cte = 0; sba = 0; sbb = 0;
    srd = 0; sula = 0; le = 0; dbg_sel = 0;
    for (int i = 0; i < NR; i++) mbank[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_cmp", out_cmp, 0);
    check("reset_flags", {out_zero, out_carry}, 0);
    check_bank();

    // Reset in the middle of a multiply aborts it
    issue(4'd10, 2'b00, 0, 0, 1, 1'b1, 8'h00, 8'h12);
    issue(4'd10, 2'b00, 0, 0, 2, 1'b1, 8'h00, 8'h34);
    drain();
    issue(4'd8, 2'b00, 1, 2, 6, 1'b1, 8'h00, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    q.delete();
    for (int i = 0; i < NR; i++) mbank[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    drain();
    check_bank();

    // Back-to-back LOAD then ADD using the forwarded r3
    issue(4'd10, 2'b00, 0, 0, 3, 1'b1, 8'h00, 8'h25);
    issue(4'd0, 2'b10, 3, 0, 4, 1'b1, 8'h10, 8'h00);
    issue(4'd1, 2'b00, 3, 4, 5, 1'b1, 8'h00, 8'h00);
    drain();
    check_reg(4, 8'h35);
    check_reg(5, 8'hF0);
    check("sub_out_data", out_data, 8'hF0);
    check("sub_out_cmp", out_cmp, 5'b00011);
    check("sub_flags{z,c}", {out_zero, out_carry}, 2'b01);

    // Multiply 0x12 * 0x34 = 0x03A8
    issue(4'd10, 2'b00, 0, 0, 1, 1'b1, 8'h00, 8'h12);
    issue(4'd10, 2'b00, 0, 0, 2, 1'b1, 8'h00, 8'h34);
    issue(4'd8, 2'b00, 1, 2, 6, 1'b1, 8'h00, 8'h00);
    mul_low = 0;
    while (!in_ready && mul_low < 100) begin mul_low++; @(posedge clk); #1; end
    check("mul_ready_low_cycles", mul_low, W);
    drain();
    check_reg(6, 8'hA8);
    check_reg(7, 8'h03);
    check("mul_out_carry", out_carry, 1);

    // 0xFF * 0xFF into r15 with the high half wrapping to r0
    issue(4'd10, 2'b00, 0, 0, 8, 1'b1, 8'h00, 8'hFF);
    issue(4'd8, 2'b00, 8, 8, 15, 1'b1, 8'h00, 8'h00);
    drain();
    check_reg(15, 8'h01);
    check_reg(0, 8'hFE);
    check("wrap_out_carry", out_carry, 1);

    // Both operands from cte, no write; then a NOP with le set
    issue(4'd1, 2'b11, 0, 0, 9, 1'b0, 8'h7F, 8'h00);
    drain();
    check("cte_out_cmp", out_cmp, 5'b01110);
    check("cte_out_zero", out_zero, 1);
    check("cte_out_data", out_data, 0);
    issue(4'd12, 2'b00, 2, 3, 9, 1'b1, 8'h00, 8'h00);
    drain();
    check_bank();

    // Randomized instruction stream with occasional bubbles
    for (int n = 0; n < 300; n++) begin
      issue(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            $urandom_range(0, NR - 1), $urandom_range(0, NR - 1),
            $urandom_range(0, NR - 1), 1'($urandom_range(0, 1)),
            W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();
    check_bank();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
